// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the IF stage: HALT opcode, NOP word, FSM state
// encoding and the sequential PC increment.
package instruction_fetch_pkg;
   localparam logic [5:0]  HALT_OPCODE = 6'b111111;
   localparam logic [31:0] NOP         = 32'h0;
   localparam logic [31:0] PC_STEP     = 32'd4;

   localparam logic [1:0]  ST_LOAD = 2'd0;
   localparam logic [1:0]  ST_RUN  = 2'd1;
   localparam logic [1:0]  ST_HALT = 2'd2;
endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store, MEM_DEPTH x NB, no reset.
// Ports:
//   i_clk   - clock, write happens on the rising edge
//   i_we    - write enable
//   i_waddr - word index written
//   i_wdata - word written
//   i_raddr - word index read (asynchronous)
//   o_rdata - word at i_raddr
module instruction_memory #(
   parameter int NB        = 32,
   parameter int MEM_DEPTH = 64,
   parameter int ADDR_NB   = 6
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [ADDR_NB-1:0] i_waddr,
   input  logic [NB-1:0]      i_wdata,
   input  logic [ADDR_NB-1:0] i_raddr,
   output logic [NB-1:0]      o_rdata
);
   logic [NB-1:0] r_mem [MEM_DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline. Owns the PC and the instruction
// memory, presents the registered instruction, its PC and PC+4 to ID.
// Ports:
//   i_clk, i_reset            - clock / synchronous active-low reset
//   i_step                    - advance enable (debug step or tied high)
//   i_load_en/addr/data       - debug memory write, accepted only in LOAD
//   i_start                   - leave LOAD, begin fetching at PC 0
//   i_stall                   - hazard stall, freezes fetch and redirects
//   i_branch_taken/addr       - branch redirect
//   i_jump/i_jump_addr        - jump redirect (higher priority than branch)
//   o_pc, o_pc4, o_instruction- fetched word and its PC / PC+4
//   o_halt                    - HALT word fetched, pipeline draining
//   o_running                 - FSM in RUN
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int NB        = 32,
   parameter int MEM_DEPTH = 64,
   parameter int ADDR_NB   = 6,
   parameter int CTRLNB    = 6
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_step,
   input  logic               i_load_en,
   input  logic [ADDR_NB-1:0] i_load_addr,
   input  logic [NB-1:0]      i_load_data,
   input  logic               i_start,
   input  logic               i_stall,
   input  logic               i_branch_taken,
   input  logic [NB-1:0]      i_branch_addr,
   input  logic               i_jump,
   input  logic [NB-1:0]      i_jump_addr,
   output logic [NB-1:0]      o_pc,
   output logic [NB-1:0]      o_pc4,
   output logic [NB-1:0]      o_instruction,
   output logic               o_halt,
   output logic               o_running
);
   logic [1:0]    r_state;
   logic [NB-1:0] r_pc;
   logic [NB-1:0] r_out_pc;
   logic [NB-1:0] r_out_pc4;
   logic [NB-1:0] r_instr;
   logic          r_halt;

   logic [NB-1:0] w_word;
   logic [NB-1:0] w_pc4;
   logic          w_we;
   logic          w_redirect;
   logic [NB-1:0] w_target;
   logic          w_is_halt;

   // Writes are blocked during reset and outside LOAD.
   assign w_we = i_reset && i_load_en && (r_state == ST_LOAD);

   instruction_memory #(
      .NB        (NB),
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_NB   (ADDR_NB)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (i_load_addr),
      .i_wdata (i_load_data),
      .i_raddr (r_pc[ADDR_NB+1:2]),   // byte PC -> word index, wraps
      .o_rdata (w_word)
   );

   assign w_pc4      = r_pc + NB'(PC_STEP);
   assign w_redirect = i_jump || i_branch_taken;
   assign w_target   = i_jump ? i_jump_addr : i_branch_addr;
   assign w_is_halt  = (w_word[NB-1 -: CTRLNB] == HALT_OPCODE);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state   <= ST_LOAD;
         r_pc      <= '0;
         r_out_pc  <= '0;
         r_out_pc4 <= '0;
         r_instr   <= NB'(NOP);
         r_halt    <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (i_start) begin
                  r_state <= ST_RUN;
                  r_pc    <= '0;
               end
            end
            ST_RUN: begin
               // Stall dominates everything, including redirects.
               if (i_step && !i_stall) begin
                  r_out_pc  <= r_pc;
                  r_out_pc4 <= w_pc4;
                  if (w_redirect) begin
                     // No delay slot: the wrong-path word is squashed,
                     // which also hides a HALT sitting in that slot.
                     r_pc    <= w_target;
                     r_instr <= NB'(NOP);
                  end else begin
                     r_instr <= w_word;
                     r_pc    <= w_pc4;
                     if (w_is_halt) begin
                        r_state <= ST_HALT;
                        r_halt  <= 1'b1;
                     end
                  end
               end
            end
            ST_HALT: begin
               // Drain: feed NOPs, keep o_pc/o_pc4 at the HALT word.
               if (i_step) r_instr <= NB'(NOP);
            end
            default: r_state <= ST_LOAD;
         endcase
      end
   end

   assign o_pc          = r_out_pc;
   assign o_pc4         = r_out_pc4;
   assign o_instruction = r_instr;
   assign o_halt        = r_halt;
   assign o_running     = (r_state == ST_RUN);
endmodule
